fan_tach_monitor: RTL and testbench
===================================

Name: fan_tach_monitor

Overview:
- Measures fan speed from the fan's open-drain tachometer output by counting debounced falling edges over a fixed measurement window.
- Publishes the latched pulse count and a stall flag for software or board-control logic.
- Sits beside the fan PWM driver on the FPGA board top and closes the loop on the PWM setting.

Parameters:
- WindowCycles, 50000000: clk_i cycles per measurement window (1 s at 50 MHz). Must be >= 2.
- DebounceCycles, 8: consecutive stable cycles required before the filtered tach level changes. Must be >= 1.
- CntWidth, 16: width of the pulse counter and count output.
- StallWindows, 2: consecutive below-threshold windows needed to assert stall_o. Must be >= 1.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset. Asynchronous, active-low.
- en_i  input  1  measurement enable
- tach_i  input  1  raw fan tach signal. Asynchronous to clk_i; idles high via pull-up.
- stall_thresh_i  input  CntWidth  minimum healthy pulse count per window. 0 disables stall detection.
- tach_count_o  output  CntWidth  falling-edge count of the last completed window
- count_valid_o  output  1  one-cycle strobe; tach_count_o updated this cycle
- stall_o  output  1  fan stalled or too slow

Behaviour:
- Reset (async assert, sync release):
  - tach_count_o = 0, count_valid_o = 0, stall_o = 0.
  - Synchronizer flops and filtered level reset to 1.
  - All internal counters reset to 0. FSM resets to IDLE.
- Synchronizer: two-flop synchronizer on tach_i. No logic before the first flop.
- Debounce:
  - A counter increments while the synchronized level differs from the filtered level, and clears whenever they are equal.
  - When the counter reaches DebounceCycles, the filtered level takes the synchronized value and the counter clears.
  - A pulse shorter than DebounceCycles never changes the filtered level.
  - Latency from a tach_i edge to the filtered edge is 2 + DebounceCycles cycles.
  - Synchronizer and debounce run regardless of en_i.
- Edge detect: a filtered 1->0 transition produces a one-cycle edge event.
- FSM states:
  - IDLE: window counter, accumulator, and stall counter held at 0; stall_o = 0; no strobes; tach_count_o keeps its last value. en_i = 1 -> MEASURE next cycle, window counter starts at 0.
  - MEASURE: window counter increments each cycle from 0 to WindowCycles-1. en_i = 0 in any cycle -> IDLE; the partial window is discarded, with no strobe and no count update.
- Window close (the cycle the window counter = WindowCycles-1 in MEASURE):
  - An edge event in this same cycle is included in the closing window.
  - tach_count_o <= accumulator (plus that edge), and count_valid_o = 1 on the following cycle, aligned with the new tach_count_o.
  - Accumulator restarts at 0 and the window counter wraps to 0. Windows are back-to-back with no gap cycle.
- Accumulator arithmetic: unsigned, saturating at 2^CntWidth-1; no wrap.
- Stall (evaluated at each window close using the closing count):
  - If stall_thresh_i != 0 and count < stall_thresh_i: the stall counter increments, saturating at StallWindows.
  - Otherwise the stall counter clears.
  - stall_o is registered: 1 iff stall counter == StallWindows, and it updates in the same cycle as count_valid_o.
  - stall_thresh_i is sampled only at window close.
  - Changing stall_thresh_i to 0 clears stall_o at the next window close.
- Reset mid-window: all state returns to reset values immediately; no strobe is produced.

Test Plan:
1. Reset check: hold rst_ni low with tach_i toggling -> tach_count_o = 0, count_valid_o = 0, stall_o = 0. After release with en_i = 0 for 5000 cycles, there are no strobes.
2. Nominal count (WindowCycles = 1000, DebounceCycles = 4): en_i = 1, tach_i square wave with period 100 cycles -> count_valid_o pulses exactly every 1000 cycles, tach_count_o = 10 each window (9 or 10 for the first window, depending on phase), and stall_o stays 0 with stall_thresh_i = 5.
3. Glitch rejection: tach_i high with 3-cycle low glitches every 50 cycles -> tach_count_o = 0. Widen the glitches to 6 cycles -> tach_count_o = 20.
4. Saturation (CntWidth = 4): 20 clean pulses per window -> tach_count_o = 15, with no wrap.
5. Stall assert/clear (stall_thresh_i = 5, StallWindows = 2):
   - Stop tach -> stall_o = 1 coincident with the 2nd zero-count strobe, not the 1st.
   - Restart 10 pulses/window -> stall_o = 0 at the next strobe.
   - Set stall_thresh_i = 0 while stalled -> stall_o clears at the next strobe.
6. Enable abort: drop en_i at cycle 600 of a window -> no strobe, tach_count_o unchanged, stall_o = 0. Re-enable -> first strobe arrives exactly WindowCycles+1 cycles after en_i rises (1 cycle into MEASURE, WindowCycles cycles of window, strobe on the following cycle).

Source files
------------

// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor.
// Counts debounced falling edges of the open-drain fan tach signal over a fixed window of
// WindowCycles clocks, publishes the count of each completed window, and flags a stalled or
// slow fan after StallWindows consecutive windows below the threshold.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   en_i           measurement enable; dropping it discards the window in progress
//   tach_i         raw tach input, asynchronous, idles high
//   stall_thresh_i minimum healthy pulses per window, 0 disables stall detection
//   tach_count_o   pulse count of the last completed window
//   count_valid_o  one-cycle strobe, tach_count_o updated this cycle
//   stall_o        fan stalled or too slow
module fan_tach_monitor #(
    parameter int unsigned WindowCycles   = 50000000,
    parameter int unsigned DebounceCycles = 8,
    parameter int unsigned CntWidth       = 16,
    parameter int unsigned StallWindows   = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                tach_i,
    input  logic [CntWidth-1:0] stall_thresh_i,
    output logic [CntWidth-1:0] tach_count_o,
    output logic                count_valid_o,
    output logic                stall_o
);

    localparam int unsigned WinW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
    localparam int unsigned DebW = $clog2(DebounceCycles + 1);
    localparam int unsigned StW  = $clog2(StallWindows + 1);

    localparam logic [WinW-1:0]     WinLast  = WinW'(WindowCycles - 1);
    localparam logic [DebW-1:0]     DebLast  = DebW'(DebounceCycles - 1);
    localparam logic [StW-1:0]      StallMax = StW'(StallWindows);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic                filt_q, filt_d;
    logic                filt_prev_q;
    logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;
    logic [WinW-1:0]     win_q, win_d;
    logic [CntWidth-1:0] acc_q, acc_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [StW-1:0]      stall_cnt_q, stall_cnt_d;
    logic                valid_q, valid_d;
    logic                stall_q, stall_d;
    logic                edge_ev;
    logic [CntWidth-1:0] acc_inc;

    // Debounce: the filtered level follows the synchronized level only after it has
    // differed for DebounceCycles consecutive cycles; any agreement restarts the count.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DebLast) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign edge_ev = filt_prev_q & ~filt_q;

    // Saturating accumulate of the current edge event.
    assign acc_inc = (acc_q == CntMax) ? acc_q : acc_q + CntWidth'(edge_ev);

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        acc_d       = acc_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        valid_d     = 1'b0;
        stall_d     = stall_q;
        unique case (state_q)
            StIdle: begin
                win_d       = '0;
                acc_d       = '0;
                stall_cnt_d = '0;
                stall_d     = 1'b0;
                if (en_i) state_d = StMeasure;
            end
            StMeasure: begin
                if (!en_i) begin
                    // Partial window is dropped: no strobe, count output untouched.
                    state_d     = StIdle;
                    win_d       = '0;
                    acc_d       = '0;
                    stall_cnt_d = '0;
                    stall_d     = 1'b0;
                end else if (win_q == WinLast) begin
                    win_d   = '0;
                    acc_d   = '0;
                    count_d = acc_inc;
                    valid_d = 1'b1;
                    if ((stall_thresh_i != '0) && (acc_inc < stall_thresh_i)) begin
                        stall_cnt_d = (stall_cnt_q == StallMax) ? StallMax
                                                                : stall_cnt_q + 1'b1;
                    end else begin
                        stall_cnt_d = '0;
                    end
                    stall_d = (stall_cnt_d == StallMax);
                end else begin
                    win_d = win_q + 1'b1;
                    acc_d = acc_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            deb_cnt_q   <= '0;
            state_q     <= StIdle;
            win_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            valid_q     <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            sync1_q     <= tach_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            valid_q     <= valid_d;
            stall_q     <= stall_d;
        end
    end

    assign tach_count_o  = count_q;
    assign count_valid_o = valid_q;
    assign stall_o       = stall_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Bench for fan_tach_monitor: a 16-bit instance and a 4-bit saturating instance share the
// tach/enable stimulus; expected strobes (cycle, count range, stall) are queued by the
// stimulus process and checked by a monitor whenever a DUT strobes.
module tb_fan_tach_monitor;

    localparam int unsigned W = 1000;

    typedef struct {
        int unsigned cyc;
        int unsigned lo;
        int unsigned hi;
        int unsigned stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tach;
    logic [15:0] thresh;
    logic [3:0]  thresh4;
    logic [15:0] cnt16;
    logic        vld16;
    logic        stall16;
    logic [3:0]  cnt4;
    logic        vld4;
    logic        stall4;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          mode = 1;
    int unsigned mode_start = 0;
    int unsigned win_end = 0;
    exp_t        q16[$];
    exp_t        q4[$];

    fan_tach_monitor #(
        .WindowCycles(W), .DebounceCycles(4), .CntWidth(16), .StallWindows(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tach_i(tach),
        .stall_thresh_i(thresh), .tach_count_o(cnt16), .count_valid_o(vld16),
        .stall_o(stall16)
    );

    fan_tach_monitor #(
        .WindowCycles(W), .DebounceCycles(4), .CntWidth(4), .StallWindows(2)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tach_i(tach),
        .stall_thresh_i(thresh4), .tach_count_o(cnt4), .count_valid_o(vld4),
        .stall_o(stall4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tach patterns: 1 = 100-cycle square, 2 = 3-cycle low glitch every 50,
    // 3 = 6-cycle low pulse every 50, otherwise idle high.
    initial begin
        int unsigned t;
        tach = 1'b1;
        forever begin
            @(negedge clk);
            t = cyc - mode_start;
            case (mode)
                1: tach = ((t % 100) >= 50);
                2: tach = ((t % 50) >= 3);
                3: tach = ((t % 50) >= 6);
                default: tach = 1'b1;
            endcase
        end
    end

    task automatic check(input string name, input longint act, input longint lo,
                         input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d..%0d", name, cyc, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vld16) begin
            if (q16.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe16 @cyc %0d: got strobe, required none", cyc);
            end else begin
                e = q16.pop_front();
                check("strobe_cycle16", cyc, e.cyc, e.cyc);
                check("count16", cnt16, e.lo, e.hi);
                check("stall16", stall16, e.stall, e.stall);
            end
        end
        if (vld4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe4 @cyc %0d: got strobe, required none", cyc);
            end else begin
                e = q4.pop_front();
                check("strobe_cycle4", cyc, e.cyc, e.cyc);
                check("count4_sat", cnt4, e.lo, e.hi);
                check("stall4", stall4, e.stall, e.stall);
            end
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input int m);
        mode       = m;
        mode_start = cyc;
    endtask

    // Queue the next window's expected strobe for both instances.
    task automatic push(input int unsigned lo, input int unsigned hi, input int unsigned st);
        exp_t e;
        win_end += W;
        e.cyc   = win_end;
        e.lo    = lo;
        e.hi    = hi;
        e.stall = st;
        q16.push_back(e);
        e.lo    = (lo > 15) ? 15 : lo;
        e.hi    = (hi > 15) ? 15 : hi;
        e.stall = 0;
        q4.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input int unsigned c16,
                                 input int unsigned c4, input int unsigned st);
        check({tag, "_count16"}, cnt16, c16, c16);
        check({tag, "_count4"}, cnt4, c4, c4);
        check({tag, "_valid"}, vld16 | vld4, 0, 0);
        check({tag, "_stall"}, stall16, st, st);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        thresh  = 16'd5;
        thresh4 = 4'd0;
        set_mode(1);

        // Reset held with tach toggling, then idle with en low.
        wait_cycles(50);
        check_outputs("reset_a", 0, 0, 0);
        wait_cycles(150);
        check_outputs("reset_b", 0, 0, 0);
        rst_n = 1'b1;
        wait_cycles(5000);
        check_outputs("idle", 0, 0, 0);

        // Nominal square wave, exact strobe spacing.
        en      = 1'b1;
        win_end = cyc + 1;
        push(9, 10, 0);
        push(10, 10, 0);
        push(10, 10, 0);
        wait_until(win_end);

        // Glitch rejection then 6-cycle pulses (saturates the 4-bit instance).
        thresh = 16'd0;
        set_mode(2);
        push(0, 65535, 0);
        push(0, 0, 0);
        push(0, 0, 0);
        wait_until(win_end);
        set_mode(3);
        push(0, 65535, 0);
        push(20, 20, 0);
        push(20, 20, 0);
        wait_until(win_end);

        // Stall on the second zero-count window, clear on restart.
        set_mode(0);
        push(0, 65535, 0);
        wait_until(win_end);
        thresh = 16'd5;
        push(0, 0, 0);
        push(0, 0, 1);
        wait_until(win_end);
        set_mode(1);
        push(9, 10, 0);
        push(10, 10, 0);
        wait_until(win_end);

        // Stall again, then disable detection while stalled.
        thresh = 16'd0;
        set_mode(0);
        push(0, 65535, 0);
        wait_until(win_end);
        thresh = 16'd5;
        push(0, 0, 0);
        push(0, 0, 1);
        push(0, 0, 1);
        wait_until(win_end);
        thresh = 16'd0;
        push(0, 0, 0);
        wait_until(win_end);

        // Enable abort at window cycle 600, then re-enable.
        set_mode(1);
        push(0, 65535, 0);
        push(10, 10, 0);
        wait_until(win_end);
        wait_until(win_end + 600);
        en = 1'b0;
        wait_cycles(2000);
        check_outputs("abort", 10, 10, 0);
        en      = 1'b1;
        win_end = cyc + 1;
        push(10, 10, 0);
        push(10, 10, 0);
        wait_until(win_end);

        // Reset mid-window.
        wait_cycles(300);
        rst_n = 1'b0;
        en    = 1'b0;
        wait_cycles(3);
        check_outputs("midreset", 0, 0, 0);
        rst_n = 1'b1;
        wait_cycles(1500);
        check_outputs("post_reset", 0, 0, 0);

        check("pending_strobes16", q16.size(), 0, 0);
        check("pending_strobes4", q4.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
